// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state constants and lane/extension helpers for the
// dmem_pipe data memory.
package dmem_pkg;

   localparam int LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_RESET = 2'd0;
   localparam state_t ST_CLEAR = 2'd1;
   localparam state_t ST_RUN   = 2'd2;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SZ_BYTE: mask = 4'b0001 << off;
         SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // Bytes are shifted down to bit 0; size[2] selects zero- over sign-extension.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size,
                                               input logic [1:0] off);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {off, 3'b000};
      result  = 32'h0;
      case (size[1:0])
         SZ_BYTE: result = size[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = size[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         SZ_WORD: result = word;
         default: result = 32'h0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word-wide RAM with per-byte-lane write enables and a registered
// read port; coded for block-RAM inference.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int WORDS = 16384,
   parameter int IDX_W = $clog2(WORDS)
) (
   input  logic                   clock,
   input  logic                   en_i,
   input  logic [LANES-1:0]       we_i,
   input  logic [IDX_W-1:0]       addr_i,
   input  logic [8*LANES-1:0]     wdata_i,
   output logic [8*LANES-1:0]     rdata_o
);

   logic [8*LANES-1:0] mem_q [WORDS];
   logic [8*LANES-1:0] rdata_q;

   // NOTE: the array has no reset branch; a reset would block RAM inference and contents must survive reset anyway.
   always_ff @(posedge clock) begin
      if (en_i) begin
         for (int l = 0; l < LANES; l++) begin
            if (we_i[l]) mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined load/store data memory: request decode, control FSM and fixed-latency
// response pipeline. Define DMEM_CLEAR_EN to zero-sweep the memory after reset.
module dmem_pipe
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
   parameter int          DEPTH_BYTES  = 65536,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_size,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int WORDS = DEPTH_BYTES / LANES;
   localparam int IDX_W = $clog2(WORDS);

   state_t            state_q, state_d;
   logic [31:0]       off;
   logic              accept, range_err, size_err, align_err, req_err;
   logic [31:0]       wdata_lanes;
   logic              bank_en;
   logic [3:0]        bank_we;
   logic [IDX_W-1:0]  bank_addr;
   logic [31:0]       bank_wdata, bank_rdata;
`ifdef DMEM_CLEAR_EN
   logic [IDX_W-1:0]  clr_q, clr_d;
`endif

   assign req_ready = (state_q == ST_RUN);
   assign accept    = req_valid && req_ready;
   assign off       = req_address - BASE_ADDR;

   // Addresses below the base wrap to a huge offset, so one compare covers both ends.
   always_comb begin
      range_err = (off >= 32'(DEPTH_BYTES));
      size_err  = (req_size[1:0] == 2'b11);
      align_err = 1'b0;
      case (req_size[1:0])
         SZ_HALF: align_err = off[0];
         SZ_WORD: align_err = |off[1:0];
         default: align_err = 1'b0;
      endcase
      req_err = range_err | size_err | align_err;
   end

   always_comb begin
      case (req_size[1:0])
         SZ_BYTE: wdata_lanes = {4{req_wdata[7:0]}};
         SZ_HALF: wdata_lanes = {2{req_wdata[15:0]}};
         default: wdata_lanes = req_wdata;
      endcase
   end

   // NOTE: every output gets a default before any branch so no latch is inferred.
   always_comb begin
      state_d = state_q;
`ifdef DMEM_CLEAR_EN
      clr_d   = clr_q;
`endif
      case (state_q)
         ST_RESET: begin
`ifdef DMEM_CLEAR_EN
            state_d = ST_CLEAR;
            clr_d   = '0;
`else
            state_d = ST_RUN;
`endif
         end
`ifdef DMEM_CLEAR_EN
         ST_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == IDX_W'(WORDS - 1)) state_d = ST_RUN;
         end
`endif
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_RESET;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_RESET;
`ifdef DMEM_CLEAR_EN
         clr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef DMEM_CLEAR_EN
         clr_q   <= clr_d;
`endif
      end
   end

   always_comb begin
      bank_en    = accept;
      bank_addr  = off[IDX_W+1:2];
      bank_wdata = wdata_lanes;
      bank_we    = (accept && req_write && !req_err) ? lane_mask(req_size[1:0], off[1:0]) : 4'b0000;
`ifdef DMEM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         bank_en    = 1'b1;
         bank_addr  = clr_q;
         bank_wdata = 32'h0;
         bank_we    = 4'b1111;
      end
`endif
   end

   dmem_bank #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
   ) u_bank (
      .clock   (clock),
      .en_i    (bank_en),
      .we_i    (bank_we),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata)
   );

   // First stage lines up with the RAM read; payload regs are qualified by the valid bits.
   logic        s0_valid_q, s0_load_q, s0_err_q;
   logic [2:0]  s0_size_q;
   logic [1:0]  s0_off_q;
   logic [31:0] s0_rdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         s0_valid_q <= 1'b0;
         s0_load_q  <= 1'b0;
      end else begin
         s0_valid_q <= accept;
         s0_load_q  <= accept && !req_write && !req_err;
      end
   end

   always_ff @(posedge clock) begin
      s0_err_q  <= req_err;
      s0_size_q <= req_size;
      s0_off_q  <= off[1:0];
   end

   assign s0_rdata = s0_load_q ? load_extend(bank_rdata, s0_size_q, s0_off_q) : 32'h0;

   generate
      if (READ_LATENCY <= 1) begin : g_lat1
         assign rsp_valid = s0_valid_q;
         assign rsp_error = s0_valid_q & s0_err_q;
         assign rsp_rdata = s0_rdata;
      end else begin : g_latn
         localparam int N = READ_LATENCY - 1;
         logic [N-1:0] v_q;
         logic [N-1:0] e_q;
         logic [31:0]  d_q [N];

         always_ff @(posedge clock) begin
            if (reset) begin
               v_q <= '0;
            end else begin
               v_q[0] <= s0_valid_q;
               for (int i = 1; i < N; i++) v_q[i] <= v_q[i-1];
            end
         end

         always_ff @(posedge clock) begin
            e_q[0] <= s0_valid_q & s0_err_q;
            d_q[0] <= s0_rdata;
            for (int i = 1; i < N; i++) begin
               e_q[i] <= e_q[i-1];
               d_q[i] <= d_q[i-1];
            end
         end

         assign rsp_valid = v_q[N-1];
         assign rsp_error = v_q[N-1] & e_q[N-1];
         assign rsp_rdata = v_q[N-1] ? d_q[N-1] : 32'h0;
      end
   endgenerate

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe: vector table plus scoreboard, with
// hand-written streaming, reset-flush and (with DMEM_CLEAR_EN) clear-sweep sequences.
module tb_dmem_pipe;

   localparam int          LAT   = 3;
   localparam int          DEPTH = 65536;
   localparam int          WORDS = DEPTH / 4;
   localparam logic [31:0] BASE  = 32'h0100_0000;
`ifdef DMEM_CLEAR_EN
   localparam int          EXP_LOW    = WORDS;
   localparam logic [31:0] EXP_RETAIN = 32'h0;
`else
   localparam int          EXP_LOW    = 0;
   localparam logic [31:0] EXP_RETAIN = 32'hDEAD_55EF;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_address, req_wdata;
   logic [2:0]  req_size;
   logic        rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;

   dmem_pipe #(
      .BASE_ADDR    (BASE),
      .DEPTH_BYTES  (DEPTH),
      .READ_LATENCY (LAT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .req_size    (req_size),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_error   (rsp_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          rsp_cnt = 0;
   logic [31:0] drv_rdata;
   logic        drv_err;
   string       drv_name;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: requests are recorded when they will be accepted at the next edge.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         sb_q.delete();
      end else begin
         if (rsp_valid) begin
            rsp_cnt++;
            if (sb_q.size() == 0) begin
               check("spurious rsp_valid", {31'h0, rsp_valid}, 32'h0);
            end else begin
               e = sb_q.pop_front();
               check({e.name, " rdata"}, rsp_rdata, e.rdata);
               check({e.name, " error"}, {31'h0, rsp_error}, {31'h0, e.err});
               check({e.name, " latency"}, cyc - e.cyc, LAT);
            end
         end
         if (req_valid && req_ready) begin
            e.rdata = drv_rdata;
            e.err   = drv_err;
            e.cyc   = cyc;
            e.name  = drv_name;
            sb_q.push_back(e);
         end
      end
   end

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] size, input logic [31:0] exp_rdata,
                               input logic exp_err, input string name);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
      return v;
   endfunction

   task automatic issue(input vec_t v);
      @(posedge clock);
      #1;
      req_valid   = 1'b1;
      req_write   = v.wr;
      req_address = v.addr;
      req_wdata   = v.wdata;
      req_size    = v.size;
      drv_rdata   = v.exp_rdata;
      drv_err     = v.exp_err;
      drv_name    = v.name;
   endtask

   task automatic idle();
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check({name, " drain"}, sb_q.size(), 0);
   endtask

   // Call right after the first edge that samples reset low.
   task automatic wait_ready(input string name);
      int low;
      low = 0;
      @(negedge clock);
      while (!req_ready && low < 70000) begin
         low++;
         @(negedge clock);
      end
      check({name, " ready-low cycles"}, low, EXP_LOW);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      int   base_cnt;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_address = 32'h0; req_wdata = 32'h0; req_size = 3'b000;
      drv_rdata = 32'h0; drv_err = 1'b0; drv_name = "none";

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset req_ready", {31'h0, req_ready}, 32'h0);
      check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset rsp_error", {31'h0, rsp_error}, 32'h0);

      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock);
      wait_ready("power-up");

`ifdef DMEM_CLEAR_EN
      issue(mk(1'b0, 32'h0100_0020, 32'h0, 3'b010, 32'h0, 1'b0, "cleared load"));
      idle();
      drain("cleared");
`endif

      tbl.push_back(mk(1, 32'h0100_0010, 32'hDEAD_BEEF, 3'b010, 32'h0,         0, "st word"));
      tbl.push_back(mk(0, 32'h0100_0010, 32'h0,        3'b010, 32'hDEAD_BEEF, 0, "ld word"));
      tbl.push_back(mk(0, 32'h0100_0013, 32'h0,        3'b000, 32'hFFFF_FFDE, 0, "ld byte sx"));
      tbl.push_back(mk(0, 32'h0100_0013, 32'h0,        3'b100, 32'h0000_00DE, 0, "ld byte zx"));
      tbl.push_back(mk(0, 32'h0100_0012, 32'h0,        3'b001, 32'hFFFF_DEAD, 0, "ld half sx"));
      tbl.push_back(mk(0, 32'h0100_0012, 32'h0,        3'b101, 32'h0000_DEAD, 0, "ld half zx"));
      tbl.push_back(mk(1, 32'h0100_0011, 32'hAABB_CC55, 3'b000, 32'h0,        0, "st byte"));
      tbl.push_back(mk(0, 32'h0100_0010, 32'h0,        3'b010, 32'hDEAD_55EF, 0, "ld word after st byte"));
      tbl.push_back(mk(0, 32'h0100_0010, 32'h0,        3'b000, 32'hFFFF_FFEF, 0, "ld byte lane0"));
      tbl.push_back(mk(0, 32'h0100_0010, 32'h0,        3'b101, 32'h0000_55EF, 0, "ld half lo zx"));
      tbl.push_back(mk(0, 32'h0100_0002, 32'h0,        3'b010, 32'h0,         1, "ld word misaligned"));
      tbl.push_back(mk(0, 32'h0100_0011, 32'h0,        3'b001, 32'h0,         1, "ld half misaligned"));
      tbl.push_back(mk(0, 32'h0100_0010, 32'h0,        3'b011, 32'h0,         1, "ld illegal size"));
      tbl.push_back(mk(1, 32'h0100_0013, 32'h0000_FFFF, 3'b001, 32'h0,        1, "st half misaligned"));
      tbl.push_back(mk(0, 32'h0100_0010, 32'h0,        3'b010, 32'hDEAD_55EF, 0, "ld word after bad st"));
      tbl.push_back(mk(1, 32'h0100_0014, 32'h0,        3'b010, 32'h0,         0, "st word zero"));
      tbl.push_back(mk(1, 32'h0100_0016, 32'hFFFF_1234, 3'b001, 32'h0,        0, "st half hi"));
      tbl.push_back(mk(0, 32'h0100_0014, 32'h0,        3'b010, 32'h1234_0000, 0, "ld word after st half"));
      tbl.push_back(mk(1, 32'h0100_FFFC, 32'hCAFE_F00D, 3'b010, 32'h0,        0, "st last word"));
      tbl.push_back(mk(1, 32'h00FF_FFFC, 32'h1234_5678, 3'b010, 32'h0,        1, "st below base"));
      tbl.push_back(mk(0, 32'h0100_FFFC, 32'h0,        3'b010, 32'hCAFE_F00D, 0, "ld last word unchanged"));
      tbl.push_back(mk(1, 32'h0100_FFFF, 32'h0000_0080, 3'b100, 32'h0,        0, "st last byte"));
      tbl.push_back(mk(0, 32'h0100_FFFC, 32'h0,        3'b010, 32'h80FE_F00D, 0, "ld last word"));
      tbl.push_back(mk(0, 32'h0100_FFFF, 32'h0,        3'b000, 32'hFFFF_FF80, 0, "ld last byte sx"));
      tbl.push_back(mk(0, 32'h0100_FFFF, 32'h0,        3'b100, 32'h0000_0080, 0, "ld last byte zx"));
      tbl.push_back(mk(0, 32'h0101_0000, 32'h0,        3'b010, 32'h0,         1, "ld base+depth"));
      tbl.push_back(mk(0, 32'h00FF_FFFF, 32'h0,        3'b000, 32'h0,         1, "ld below base"));

      for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);
      idle();
      drain("table");

      // Streaming: eight back-to-back loads must return on eight consecutive cycles.
      for (int i = 0; i < 8; i++)
         issue(mk(1, 32'h0100_0100 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1) ^ 32'hA500_0000,
                  3'b010, 32'h0, 0, "stream st"));
      idle();
      drain("stream stores");
      base_cnt = rsp_cnt;
      for (int i = 0; i < 8; i++)
         issue(mk(0, 32'h0100_0100 + 32'(4 * i), 32'h0, 3'b010,
                  32'h0101_0101 * 32'(i + 1) ^ 32'hA500_0000, 0, $sformatf("stream ld %0d", i)));
      idle();
      drain("stream loads");
      check("stream response count", rsp_cnt - base_cnt, 8);

      // Reset with two loads in flight: neither may produce a response.
      issue(mk(0, 32'h0100_0100, 32'h0, 3'b010, 32'h0, 0, "flushed ld a"));
      issue(mk(0, 32'h0100_0104, 32'h0, 3'b010, 32'h0, 0, "flushed ld b"));
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      base_cnt  = rsp_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rsp_valid during reset", {31'h0, rsp_valid}, 32'h0);
         if (i > 0) check("req_ready during reset", {31'h0, req_ready}, 32'h0);
      end
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock);
      wait_ready("after flush");
      repeat (6) @(negedge clock);
      check("responses after flush", rsp_cnt - base_cnt, 0);

      issue(mk(0, 32'h0100_0010, 32'h0, 3'b010, EXP_RETAIN, 0, "ld after reset"));
      idle();
      drain("after reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
